// File: rtl/dsp_mac_feeder.sv
// ============================================================================
//  Module   : dsp_mac_feeder
//  Purpose  : Feeds operand pairs into an external DSP48-style multiply-add
//             macro (P = A*B + C), chains the partial sum back through C and
//             returns the frame result on a valid/ready handshake.
//             One pair is in flight at a time; a pair is accepted every
//             DSP_LATENCY+1 cycles at most.
//  Option   : `define DSP_MAC_FEEDER_CNT_EN adds the m_count output
//             (pairs per frame, 16-bit, wraps).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dsp_mac_feeder #(
    parameter int A_W         = 18,
    parameter int B_W         = 18,
    parameter int P_W         = 48,
    parameter int DSP_LATENCY = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [A_W-1:0] s_a,
    input  logic [B_W-1:0] s_b,
    input  logic           s_last,
    output logic [A_W-1:0] dsp_a,
    output logic [B_W-1:0] dsp_b,
    output logic [P_W-1:0] dsp_c,
    input  logic [P_W-1:0] dsp_p,
    output logic           m_valid,
    input  logic           m_ready,
`ifdef DSP_MAC_FEEDER_CNT_EN
    output logic [15:0]    m_count,
`endif
    output logic [P_W-1:0] m_acc
);

    // Latency counter is 4 bits wide: DSP_LATENCY is limited to 1..15.
    localparam logic [3:0] LAT_CNT = 4'(DSP_LATENCY);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           first_q, first_d;     // next accepted pair opens a frame
    logic           last_q, last_d;       // pair in flight closes the frame
    logic [A_W-1:0] dsp_a_q, dsp_a_d;
    logic [B_W-1:0] dsp_b_q, dsp_b_d;
    logic [P_W-1:0] dsp_c_q, dsp_c_d;
    logic [P_W-1:0] psum_q, psum_d;       // running sum fed back through C
    logic           m_valid_q, m_valid_d;
    logic [P_W-1:0] m_acc_q, m_acc_d;
`ifdef DSP_MAC_FEEDER_CNT_EN
    logic [15:0]    pairs_q, pairs_d;
`endif

    // Next-state and datapath update; every register holds unless changed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        last_d    = last_q;
        dsp_a_d   = dsp_a_q;
        dsp_b_d   = dsp_b_q;
        dsp_c_d   = dsp_c_q;
        psum_d    = psum_q;
        m_valid_d = m_valid_q;
        m_acc_d   = m_acc_q;
`ifdef DSP_MAC_FEEDER_CNT_EN
        pairs_d   = pairs_q;
`endif
        case (state_q)
            ST_INIT: begin
                state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (s_valid) begin
                    dsp_a_d = s_a;
                    dsp_b_d = s_b;
                    dsp_c_d = first_q ? '0 : psum_q;
                    last_d  = s_last;
                    cnt_d   = LAT_CNT;
                    state_d = ST_WAIT;
`ifdef DSP_MAC_FEEDER_CNT_EN
                    pairs_d = first_q ? 16'd1 : pairs_q + 16'd1;
`endif
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Final wait cycle: P now reflects the operands in flight.
                if (cnt_q <= 4'd1) begin
                    cnt_d  = '0;
                    psum_d = dsp_p;
                    if (last_q) begin
                        m_acc_d   = dsp_p;
                        m_valid_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        first_d = 1'b0;
                        state_d = ST_ACCEPT;
                    end
                end
            end
            ST_DONE: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    first_d   = 1'b1;
                    state_d   = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            dsp_a_q   <= '0;
            dsp_b_q   <= '0;
            dsp_c_q   <= '0;
            psum_q    <= '0;
            m_valid_q <= 1'b0;
            m_acc_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            last_q    <= last_d;
            dsp_a_q   <= dsp_a_d;
            dsp_b_q   <= dsp_b_d;
            dsp_c_q   <= dsp_c_d;
            psum_q    <= psum_d;
            m_valid_q <= m_valid_d;
            m_acc_q   <= m_acc_d;
        end
    end

`ifdef DSP_MAC_FEEDER_CNT_EN
    // Pair counter for the frame in progress; wraps past 65535.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pairs_q <= '0;
        end else begin
            pairs_q <= pairs_d;
        end
    end

    assign m_count = pairs_q;
`endif

    assign s_ready = (state_q == ST_ACCEPT);
    assign dsp_a   = dsp_a_q;
    assign dsp_b   = dsp_b_q;
    assign dsp_c   = dsp_c_q;
    assign m_valid = m_valid_q;
    assign m_acc   = m_acc_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_mac_feeder.sv
// ============================================================================
//  Module   : tb_dsp_mac_feeder
//  Purpose  : Self-checking bench for dsp_mac_feeder with a behavioural DSP
//             multiply-add model and a frame-level sum reference.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dsp_mac_feeder;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int P_W = 48;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [A_W-1:0] s_a = '0;
    logic [B_W-1:0] s_b = '0;
    logic           s_last = 1'b0;
    logic [A_W-1:0] dsp_a;
    logic [B_W-1:0] dsp_b;
    logic [P_W-1:0] dsp_c;
    logic [P_W-1:0] dsp_p;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [P_W-1:0] m_acc;
`ifdef DSP_MAC_FEEDER_CNT_EN
    logic [15:0]    m_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [A_W-1:0] qa[$];
    logic [B_W-1:0] qb[$];

    dsp_mac_feeder #(
        .A_W(A_W), .B_W(B_W), .P_W(P_W), .DSP_LATENCY(LAT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready),
`ifdef DSP_MAC_FEEDER_CNT_EN
        .m_count(m_count),
`endif
        .m_acc(m_acc)
    );

    always #5 clk = ~clk;

    // Signed A*B product, wrapped to the accumulator width.
    function automatic logic [P_W-1:0] mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic signed [P_W-1:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return P_W'(x * y);
    endfunction

    // DSP macro model: P = A*B + C, valid in the LAT-th cycle after operands change.
    logic [P_W-1:0] pipe [LAT-1];
    initial for (int i = 0; i < LAT - 1; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= mul(dsp_a, dsp_b) + dsp_c;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign dsp_p = pipe[LAT-2];

    task automatic check(input string tag, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input int b);
        qa.push_back(a[A_W-1:0]);
        qb.push_back(b[B_W-1:0]);
    endtask

    // Drive the queued frame; entered and left at a negative clock edge.
    task automatic run_frame(input int hold, input bit gaps);
        logic [P_W-1:0] acc;
        int n, t;
        acc = '0;
        n = qa.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("ready_after_wait", P_W'(s_ready), P_W'(1));
            end
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            s_a = qa[k];
            s_b = qb[k];
            s_last = (k == n - 1);
            s_valid = 1'b1;
            t = 0;
            while (!s_ready && t < 30) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                check("ready_timeout", P_W'(s_ready), P_W'(1));
                s_valid = 1'b0;
                qa.delete();
                qb.delete();
                return;
            end
            @(posedge clk);
            #1;
            // Upstream keeps presenting junk; it must be ignored until ACCEPT.
            s_a = A_W'($urandom);
            s_b = B_W'($urandom);
            s_last = 1'($urandom);
            check("dsp_a", P_W'(dsp_a), P_W'(qa[k]));
            check("dsp_b", P_W'(dsp_b), P_W'(qb[k]));
            check("dsp_c", dsp_c, acc);
            for (int i = 1; i <= LAT; i++) begin
                @(negedge clk);
                check("wait_s_ready", P_W'(s_ready), P_W'(0));
                check("wait_dsp_a", P_W'(dsp_a), P_W'(qa[k]));
                check("wait_dsp_b", P_W'(dsp_b), P_W'(qb[k]));
                check("wait_dsp_c", dsp_c, acc);
                check("wait_m_valid", P_W'(m_valid), P_W'(0));
            end
            acc = acc + mul(qa[k], qb[k]);
        end
        @(negedge clk);
        check("m_valid", P_W'(m_valid), P_W'(1));
        check("m_acc", m_acc, acc);
        check("done_s_ready", P_W'(s_ready), P_W'(0));
`ifdef DSP_MAC_FEEDER_CNT_EN
        check("m_count", P_W'(m_count), P_W'(n));
`endif
        repeat (hold) begin
            @(negedge clk);
            check("hold_m_valid", P_W'(m_valid), P_W'(1));
            check("hold_m_acc", m_acc, acc);
            check("hold_s_ready", P_W'(s_ready), P_W'(0));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("release_m_valid", P_W'(m_valid), P_W'(0));
        check("release_s_ready", P_W'(s_ready), P_W'(1));
        qa.delete();
        qb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, P_W'(s_ready), P_W'(0));
        check({tag, "_m_valid"}, P_W'(m_valid), P_W'(0));
        check({tag, "_m_acc"}, m_acc, '0);
        check({tag, "_dsp_a"}, P_W'(dsp_a), '0);
        check({tag, "_dsp_b"}, P_W'(dsp_b), '0);
        check({tag, "_dsp_c"}, dsp_c, '0);
    endtask

    initial begin
        // Reset values, then a single INIT cycle before ACCEPT.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("init_s_ready", P_W'(s_ready), P_W'(0));
        @(negedge clk);
        check("accept_s_ready", P_W'(s_ready), P_W'(1));

        // Three equal pairs: C sequence 0, 6, 12 and result 18.
        push(2, 3); push(2, 3); push(2, 3);
        run_frame(0, 1'b0);

        // Single-pair frame.
        push(5, 7);
        run_frame(1, 1'b0);

        // Signed operands, result held 10 cycles under back-pressure.
        push(-4, 5); push(3, 3);
        run_frame(10, 1'b0);

        // Reset during the second pair's wait discards the frame.
        s_a = 18'd3; s_b = 18'd4; s_last = 1'b0; s_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (LAT) @(negedge clk);
        @(negedge clk);
        s_a = 18'd5; s_b = 18'd6;
        @(posedge clk);
        #1;
        check("mid_dsp_c", dsp_c, P_W'(12));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_init_s_ready", P_W'(s_ready), P_W'(0));
        @(negedge clk);
        check("post_accept_s_ready", P_W'(s_ready), P_W'(1));
        push(1, 1);
        run_frame(0, 1'b0);

        // Random frames with random values, gaps and back-pressure.
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) push(int'($urandom), int'($urandom));
            run_frame($urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute run bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
